// File: rtl/host_byte_bridge_pkg.sv
// Shared definitions for the host byte bridge: header type codes, ACK byte,
// datapath widths and FSM state encodings.
package host_byte_bridge_pkg;

  localparam int unsigned HB_WORD_W = 64;
  localparam int unsigned HB_BYTE_W = 8;
  localparam int unsigned HB_CNT_W  = 4;

  localparam logic [1:0] HB_TYPE_CMD  = 2'b00;
  localparam logic [1:0] HB_TYPE_DATA = 2'b01;
  localparam logic [1:0] HB_TYPE_READ = 2'b10;
  localparam logic [1:0] HB_TYPE_RSVD = 2'b11;

  localparam logic [HB_BYTE_W-1:0] HB_ACK_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CMD_BYTES  = 3'd1,
    ST_CMD_WAIT   = 3'd2,
    ST_DATA_BYTES = 3'd3,
    ST_DATA_WAIT  = 3'd4,
    ST_RD_WAIT    = 3'd5,
    ST_RD_BYTES   = 3'd6
`ifdef HOST_BRIDGE_CMD_ACK_EN
    , ST_ACK      = 3'd7
`endif
  } hb_state_e;

endpackage

// File: rtl/host_bridge_tx_shift.sv
// 64-bit load/shift-out serializer with byte count; byte_next_c previews the
// byte that will be at the head after the current edge.
module host_bridge_tx_shift
  import host_byte_bridge_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [HB_WORD_W-1:0] din,
  input  logic                 shift,
  output logic [HB_BYTE_W-1:0] byte_next_c,
  output logic                 last_c
);

  logic [HB_WORD_W-1:0] data_q;
  logic [HB_CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      data_q <= din;
      cnt_q  <= '0;
    end else if (shift) begin
      data_q <= {data_q[HB_WORD_W-HB_BYTE_W-1:0], HB_BYTE_W'(0)};
      cnt_q  <= cnt_q + HB_CNT_W'(1);
    end
  end

  always_comb begin
    byte_next_c = data_q[HB_WORD_W-1 -: HB_BYTE_W];
    if (load)
      byte_next_c = din[HB_WORD_W-1 -: HB_BYTE_W];
    else if (shift)
      byte_next_c = data_q[HB_WORD_W-HB_BYTE_W-1 -: HB_BYTE_W];
  end

  assign last_c = (cnt_q == HB_CNT_W'(7));

endmodule

// File: rtl/host_byte_bridge.sv
// Host byte-stream front end: parses CMD/DATA/READ packets for the core and
// serializes core output words. HOST_BRIDGE_CMD_ACK_EN adds a post-command ACK byte.
module host_byte_bridge
  import host_byte_bridge_pkg::*;
#(
  parameter int unsigned CMD_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [HB_BYTE_W-1:0] host_in,
  input  logic                 host_in_isReady,
  output logic                 host_in_canReceive,
  output logic [HB_BYTE_W-1:0] host_out,
  output logic                 host_out_isReady,
  input  logic                 host_out_canReceive,
  output logic [CMD_W-1:0]     cmd,
  output logic                 cmd_hasAny,
  input  logic                 cmd_consume,
  output logic [HB_WORD_W-1:0] core_in,
  output logic                 core_in_isReady,
  input  logic                 core_in_canReceive,
  input  logic [HB_WORD_W-1:0] core_out,
  input  logic                 core_out_isReady,
  output logic                 core_out_canReceive
);

  localparam int unsigned CB        = (CMD_W + 7) / 8;
  localparam int unsigned CMD_SHIFT = HB_WORD_W - HB_BYTE_W * CB;

  hb_state_e             state_q, state_d;
  logic [HB_CNT_W-1:0]   cnt_q, cnt_d;
  logic [HB_WORD_W-1:0]  acc_q, acc_d;

  logic                  host_in_canReceive_d, host_out_isReady_d, cmd_hasAny_d;
  logic                  core_in_isReady_d, core_out_canReceive_d;
  logic [HB_BYTE_W-1:0]  host_out_d;
  logic [CMD_W-1:0]      cmd_d;
  logic [HB_WORD_W-1:0]  core_in_d;

  logic                  tx_load, tx_shift, tx_last_c;
  logic [HB_BYTE_W-1:0]  tx_byte_c;

  logic in_fire, out_fire, cmd_fire, cin_fire, cout_fire;
  assign in_fire   = host_in_isReady & host_in_canReceive;
  assign out_fire  = host_out_isReady & host_out_canReceive;
  assign cmd_fire  = cmd_hasAny & cmd_consume;
  assign cin_fire  = core_in_isReady & core_in_canReceive;
  assign cout_fire = core_out_isReady & core_out_canReceive;

  host_bridge_tx_shift u_tx (
    .clk         (clk),
    .rst         (rst),
    .load        (tx_load),
    .din         (core_out),
    .shift       (tx_shift),
    .byte_next_c (tx_byte_c),
    .last_c      (tx_last_c)
  );

  // Next state, datapath and next-cycle output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    tx_load  = 1'b0;
    tx_shift = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_fire) begin
          cnt_d = '0;
          acc_d = '0;
          case (host_in[7:6])
            HB_TYPE_CMD:  state_d = ST_CMD_BYTES;
            HB_TYPE_DATA: state_d = ST_DATA_BYTES;
            HB_TYPE_READ: state_d = ST_RD_WAIT;
            HB_TYPE_RSVD: state_d = ST_IDLE;
          endcase
        end
      end
      ST_CMD_BYTES: begin
        // Command bytes arrive LSB first, so they enter from the top.
        if (in_fire) begin
          acc_d = {host_in, acc_q[HB_WORD_W-1:HB_BYTE_W]};
          cnt_d = cnt_q + HB_CNT_W'(1);
          if (cnt_q == HB_CNT_W'(CB - 1)) state_d = ST_CMD_WAIT;
        end
      end
      ST_CMD_WAIT: begin
        if (cmd_fire) begin
`ifdef HOST_BRIDGE_CMD_ACK_EN
          state_d = ST_ACK;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_DATA_BYTES: begin
        if (in_fire) begin
          acc_d = {acc_q[HB_WORD_W-HB_BYTE_W-1:0], host_in};
          cnt_d = cnt_q + HB_CNT_W'(1);
          if (cnt_q == HB_CNT_W'(7)) state_d = ST_DATA_WAIT;
        end
      end
      ST_DATA_WAIT: begin
        if (cin_fire) state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (cout_fire) begin
          tx_load = 1'b1;
          state_d = ST_RD_BYTES;
        end
      end
      ST_RD_BYTES: begin
        if (out_fire) begin
          tx_shift = 1'b1;
          if (tx_last_c) state_d = ST_IDLE;
        end
      end
`ifdef HOST_BRIDGE_CMD_ACK_EN
      ST_ACK: begin
        if (out_fire) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    host_in_canReceive_d  = (state_d == ST_IDLE) || (state_d == ST_CMD_BYTES) ||
                            (state_d == ST_DATA_BYTES);
    cmd_hasAny_d          = (state_d == ST_CMD_WAIT);
    cmd_d                 = cmd_hasAny_d ? CMD_W'(acc_d >> CMD_SHIFT) : '0;
    core_in_isReady_d     = (state_d == ST_DATA_WAIT);
    core_in_d             = core_in_isReady_d ? acc_d : '0;
    core_out_canReceive_d = (state_d == ST_RD_WAIT);
    host_out_isReady_d    = 1'b0;
    host_out_d            = '0;
    if (state_d == ST_RD_BYTES) begin
      host_out_isReady_d = 1'b1;
      host_out_d         = tx_byte_c;
    end
`ifdef HOST_BRIDGE_CMD_ACK_EN
    if (state_d == ST_ACK) begin
      host_out_isReady_d = 1'b1;
      host_out_d         = HB_ACK_BYTE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= ST_IDLE;
      cnt_q               <= '0;
      acc_q               <= '0;
      host_in_canReceive  <= 1'b0;
      host_out            <= '0;
      host_out_isReady    <= 1'b0;
      cmd                 <= '0;
      cmd_hasAny          <= 1'b0;
      core_in             <= '0;
      core_in_isReady     <= 1'b0;
      core_out_canReceive <= 1'b0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      acc_q               <= acc_d;
      host_in_canReceive  <= host_in_canReceive_d;
      host_out            <= host_out_d;
      host_out_isReady    <= host_out_isReady_d;
      cmd                 <= cmd_d;
      cmd_hasAny          <= cmd_hasAny_d;
      core_in             <= core_in_d;
      core_in_isReady     <= core_in_isReady_d;
      core_out_canReceive <= core_out_canReceive_d;
    end
  end

endmodule
